// File: rtl/stopwatch_ctrl_if.sv
// Panel-side bundle between buttons/counter and the stopwatch controller.
// master drives raw buttons and the live digit word; slave returns pulses and display data.
interface stopwatch_ctrl_if;
  logic        btn_ss;
  logic        btn_lr;
  logic [43:0] num_data;
  logic        sw_ss;
  logic        sw_rst;
  logic [43:0] disp_data;
  logic [1:0]  state;
  logic        init_busy;
  logic        lap_valid;

  modport master (
    output btn_ss, btn_lr, num_data,
    input  sw_ss, sw_rst, disp_data, state, init_busy, lap_valid
  );

  modport slave (
    input  btn_ss, btn_lr, num_data,
    output sw_ss, sw_rst, disp_data, state, init_busy, lap_valid
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front panel: debounced buttons drive a 4-state FSM issuing 1-cycle ss/rst pulses and lap capture.
// Press-to-pulse latency DB_CYCLES+3 edges; no backpressure, events are never queued.
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 200,
  parameter int DB_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  stopwatch_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_RUN  = 3'b001,
    S_LAP  = 3'b010,
    S_STOP = 3'b011,
    S_INIT = 3'b100
  } state_t;

  localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_CYCLES - 1);

  // Bit 0 is the start/stop button, bit 1 is lap/reset.
  logic [1:0]      btn;
  logic [1:0]      s1, s2, db_val, db_prev;
  logic [DB_W-1:0] db_cnt [2];
  logic            ev_ss, ev_lr;

  state_t      state_q, state_nxt;
  logic        sw_ss_q, sw_ss_nxt;
  logic        sw_rst_q, sw_rst_nxt;
  logic        lap_valid_q, lap_valid_nxt;
  logic        lap_cap;
  logic [43:0] lap_reg;

  assign btn = {bus.btn_lr, bus.btn_ss};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1      <= '0;
      s2      <= '0;
      db_val  <= '0;
      db_prev <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      s1      <= btn;
      s2      <= s1;
      db_prev <= db_val;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db_val[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_MAX) begin
          db_val[i] <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Start/stop has priority; a coincident lap/reset press is dropped.
  assign ev_ss = db_val[0] & ~db_prev[0];
  assign ev_lr = db_val[1] & ~db_prev[1] & ~ev_ss;

  always_comb begin
    state_nxt  = state_q;
    sw_ss_nxt  = 1'b0;
    sw_rst_nxt = 1'b0;
    lap_cap    = 1'b0;
    case (state_q)
      S_INIT: begin
        state_nxt  = S_IDLE;
        sw_rst_nxt = 1'b1;
      end
      S_IDLE: begin
        if (ev_ss) begin
          state_nxt = S_RUN;
          sw_ss_nxt = 1'b1;
        end else if (ev_lr) begin
          sw_rst_nxt = 1'b1;
        end
      end
      S_RUN: begin
        if (ev_ss) begin
          state_nxt = S_STOP;
          sw_ss_nxt = 1'b1;
        end else if (ev_lr) begin
          state_nxt = S_LAP;
          lap_cap   = 1'b1;
        end
      end
      S_LAP: begin
        if (ev_ss) begin
          state_nxt = S_STOP;
          sw_ss_nxt = 1'b1;
        end else if (ev_lr) begin
          state_nxt = S_RUN;
        end
      end
      S_STOP: begin
        if (ev_ss) begin
          state_nxt = S_RUN;
          sw_ss_nxt = 1'b1;
        end else if (ev_lr) begin
          state_nxt  = S_IDLE;
          sw_rst_nxt = 1'b1;
        end
      end
      default: state_nxt = S_INIT;
    endcase
    lap_valid_nxt = (state_nxt == S_LAP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_INIT;
      sw_ss_q     <= 1'b0;
      sw_rst_q    <= 1'b0;
      lap_valid_q <= 1'b0;
      lap_reg     <= '0;
    end else begin
      state_q     <= state_nxt;
      sw_ss_q     <= sw_ss_nxt;
      sw_rst_q    <= sw_rst_nxt;
      lap_valid_q <= lap_valid_nxt;
      if (lap_cap) lap_reg <= bus.num_data;
    end
  end

  assign bus.sw_ss     = sw_ss_q;
  assign bus.sw_rst    = sw_rst_q;
  assign bus.lap_valid = lap_valid_q;
  assign bus.state     = state_q[1:0];
  assign bus.init_busy = state_q[2];
  assign bus.disp_data = lap_valid_q ? lap_reg : bus.num_data;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Front-panel controller for the stopwatch counter. Debounces two raw push-buttons (start/stop and lap/reset) and runs a four-state FSM. The FSM issues single-cycle `ss` and `rst` pulses to the counter and captures lap values. It also selects which 44-bit digit word (live or lapped) goes to the display driver. It sits between the board buttons and the stopwatch counter, and shares the counter's 10 kHz `clk`.

## Interface
- `DB_CYCLES`, default 200: consecutive stable cycles needed to accept a button level change (20 ms at 10 kHz).
- `DB_W`, default 8: debounce counter width; must satisfy 2^DB_W ≥ DB_CYCLES.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `btn_ss` in 1: raw start/stop button, active-high, asynchronous.
- `btn_lr` in 1: raw lap/reset button, active-high, asynchronous.
- `num_data` in 44: live digit word from the counter, 11 × 4-bit fields, hh:mm:ss:cc layout.
- `sw_ss` out 1: start/stop pulse to the counter's `ss` input.
- `sw_rst` out 1: clear pulse to the counter's `rst` input.
- `disp_data` out 44: digit word to the display.
- `state` out 2: FSM state. INIT=00, IDLE=00 after init, RUN=01, LAP=10, STOP=11. INIT is flagged separately by `init_busy`.
- `init_busy` out 1: high while the FSM is in INIT.
- `lap_valid` out 1: high while `disp_data` shows the frozen lap word.

## Operation
- **Input synchronisation:** each button passes through a 2-flop synchroniser (`s1`→`s2`).
- **Debounce (per button):**
  - `db_cnt` increments each cycle that `s2 != db_val`.
  - `db_cnt` clears whenever `s2 == db_val`.
  - When `db_cnt == DB_CYCLES-1` and the mismatch persists, `db_val <= s2` and `db_cnt <= 0`.
- **Press event:** a one-cycle combinational pulse `db_val & ~db_prev`, where `db_prev` is `db_val` delayed one cycle. Releases generate no event.
- **Simultaneous presses:** if both press events occur in the same cycle, `ss` wins and the `lr` event is dropped. Events are never queued.
- **FSM transitions:** all registered, with output pulses asserted in the same cycle as the new state.
  - **INIT:** entered on reset.
    - First cycle after `rst` deasserts: `sw_rst=1`, go to IDLE.
    - Button events in this cycle are ignored.
  - **IDLE:**
    - `ss` → RUN, `sw_ss=1`.
    - `lr` → stay in IDLE, `sw_rst=1`.
  - **RUN:**
    - `ss` → STOP, `sw_ss=1`.
    - `lr` → LAP, `lap_reg <= num_data`.
  - **LAP:**
    - `lr` → RUN; display goes live.
    - `ss` → STOP, `sw_ss=1`; display goes live.
  - **STOP:**
    - `ss` → RUN, `sw_ss=1`.
    - `lr` → IDLE, `sw_rst=1`.
- **Display select:** `disp_data = lap_valid ? lap_reg : num_data` (combinational). `lap_valid` is registered and is 1 only in LAP.
- **Counter edge requirements:**
  - The counter toggles its run flag on the falling edge of `ss`, so `sw_ss` must be exactly one cycle high with at least one cycle low between pulses. Press spacing (≥ DB_CYCLES) guarantees this.
  - The counter clears on the rising edge of `rst`, so `sw_rst` is a one-cycle pulse.
- **Run-flag tracking:** the counter's run flag is not cleared by its `rst`. The controller's RUN/LAP vs IDLE/STOP tracks it by pulse count.
  - Applying controller reset while the counter is running desynchronises them.
  - System rule: controller reset only at power-up or while stopped.

## Timing
- **Reset values:**
  - `state=00` with `init_busy=1`.
  - `sw_ss=0`, `sw_rst=0`, `lap_valid=0`.
  - `lap_reg=0`; `disp_data=num_data`.
  - All `s1`, `s2`, `db_val`, `db_prev`, `db_cnt` = 0.
- **Button held through reset:** with `db_val=0`, a button held through reset registers as a press DB_CYCLES+2 cycles after release.
- **Press latency:** with `btn` high before clock edge E1, the sequence is:
  - `s2` high after E2.
  - `db_val` high after E(2+DB_CYCLES).
  - State change and output pulse after E(3+DB_CYCLES).
  - With DB_CYCLES=200: 203 edges.
- **Pulse widths:** `sw_ss` and `sw_rst` are exactly 1 cycle. `sw_ss` and `sw_rst` are never high in the same cycle.
- **Glitch rejection:** a bounce shorter than DB_CYCLES cycles produces no event. Level hold or release timing has no effect beyond debounce.
- **Lap capture:** `lap_reg` samples `num_data` on the same edge that enters LAP. `disp_data` shows that value from the following cycle.

## Test plan
- **Init:** reset low 5 cycles, then high → `sw_rst` is high for exactly cycle 1 after release, `init_busy` falls, `state=00`, `lap_valid=0`.
- **Bounce:** DB_CYCLES=4; `btn_ss` toggles every 2 cycles for 20 cycles, then stays high → exactly one `sw_ss` pulse, 7 edges after the final stable rise; `state=01`.
- **Lap:**
  - In RUN, press `lr` while `num_data` hundredths = 3,7 → `lap_valid=1` and `disp_data[36+:8]` holds 3,7 while `num_data` keeps changing.
  - Press `lr` again → RUN, `disp_data==num_data`.
- **Stop then reset:** RUN → `ss` → STOP (one `sw_ss`) → `lr` → IDLE with one `sw_rst` pulse and no `sw_ss`.
- **Simultaneous:** in RUN, both buttons debounce on the same cycle → STOP with `sw_ss` pulse, `lap_reg` unchanged, no `sw_rst`.
- **Reset mid-LAP:** assert `rst` low asynchronously mid-cycle → `lap_valid`, `sw_ss` and `sw_rst` drop immediately, `state=00`; `disp_data` returns to `num_data`.
